// File: rtl/ins_fetch_reg.sv
// Instruction register: assembles 1..MAX_BYTES byte instructions from a valid/ready fetch
// stream and holds the decoded fields until decode acknowledges them.
module ins_fetch_reg #(
   parameter int DATA_W    = 8,
   parameter int OPC_W     = 3,
   parameter int MAX_BYTES = 3,
   parameter logic [2*(2**OPC_W)-1:0] LEN_MAP = 16'h2554,
   localparam int OPR_W = (MAX_BYTES > 1) ? (MAX_BYTES-1)*DATA_W : DATA_W
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [DATA_W-1:0]        i_data,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic                     i_flush,
   input  logic                     i_ins_ack,
   output logic                     o_ins_valid,
   output logic [OPC_W-1:0]         o_ins_func,
   output logic [DATA_W-OPC_W-1:0]  o_addr_1,
   output logic [OPR_W-1:0]         o_operand,
   output logic [1:0]               o_ins_len
);

   // state | meaning
   // OPC   | waiting for byte0 (opcode + register address)
   // OPR   | collecting operand bytes, cnt = next operand slot
   // HOLD  | instruction complete, fields held until i_ins_ack
   typedef enum logic [1:0] {S_OPC, S_OPR, S_HOLD} state_t;

   localparam int         NOPR    = (MAX_BYTES > 1) ? MAX_BYTES-1 : 1;
   localparam logic [1:0] MAX_OPR = 2'(MAX_BYTES-1);

   state_t                        state;
   logic [1:0]                    cnt;
   logic [NOPR-1:0][DATA_W-1:0]   opr_q;
   logic                          xfer;
   logic [OPC_W-1:0]              opc_in;
   logic [1:0]                    len_raw;
   logic [1:0]                    need;

   assign o_ready = !i_flush && ((state != S_HOLD) || i_ins_ack);
   assign xfer    = i_valid && o_ready;
   assign opc_in  = i_data[DATA_W-1 -: OPC_W];
   assign len_raw = LEN_MAP[{opc_in, 1'b0} +: 2];
   // Map entries longer than the configured instruction size are clamped.
   assign need    = (len_raw > MAX_OPR) ? MAX_OPR : len_raw;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= S_OPC;
         cnt         <= 2'd0;
         opr_q       <= '0;
         o_ins_valid <= 1'b0;
         o_ins_func  <= '0;
         o_addr_1    <= '0;
         o_ins_len   <= 2'd0;
      end else if (i_flush) begin
         state       <= S_OPC;
         cnt         <= 2'd0;
         o_ins_valid <= 1'b0;
      end else begin
         case (state)
            S_OPC, S_HOLD: begin
               // In HOLD a transfer only happens alongside ack, so a new byte0 retires the
               // held instruction in the same cycle.
               if (xfer) begin
                  o_ins_func <= opc_in;
                  o_addr_1   <= i_data[DATA_W-OPC_W-1:0];
                  opr_q      <= '0;
                  cnt        <= 2'd0;
                  o_ins_len  <= need;
                  if (need == 2'd0) begin
                     state       <= S_HOLD;
                     o_ins_valid <= 1'b1;
                  end else begin
                     state       <= S_OPR;
                     o_ins_valid <= 1'b0;
                  end
               end else if ((state == S_HOLD) && i_ins_ack) begin
                  state       <= S_OPC;
                  o_ins_valid <= 1'b0;
               end
            end
            S_OPR: begin
               if (xfer) begin
                  for (int i = 0; i < NOPR; i++) begin
                     if (cnt == 2'(i)) opr_q[i] <= i_data;
                  end
                  cnt <= cnt + 2'd1;
                  if (cnt == o_ins_len - 2'd1) begin
                     state       <= S_HOLD;
                     o_ins_valid <= 1'b1;
                  end
               end
            end
            default: begin
               state       <= S_OPC;
               o_ins_valid <= 1'b0;
            end
         endcase
      end
   end

   generate
      if (MAX_BYTES == 1) begin : g_no_opr
         assign o_operand = '0;
      end else begin : g_opr
         assign o_operand = opr_q;
      end
   endgenerate

endmodule
